// File: rtl/serial_sum_deserializer.sv
// serial_sum_deserializer
// Reassembles the serial adder's LSB-first result stream into parallel sum
// words. Each word is offered on a valid/ready handshake. Frames that end
// early are flagged on err_short_o. Frames that arrive while the output
// word is still waiting are dropped and flagged on err_ovf_o.
// Optional feature: define SUM_DESER_FRAME_CNT_EN to add frame_cnt_o, a
// 16-bit wrapping count of completed handshakes.
module serial_sum_deserializer #(
  parameter int RESULT_W = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ser_en_i,
  input  logic                ser_d_i,
  output logic [RESULT_W-1:0] sum_o,
  output logic                sum_valid_o,
  input  logic                sum_ready_i,
  output logic                err_short_o,
  output logic                err_ovf_o
`ifdef SUM_DESER_FRAME_CNT_EN
  ,
  output logic [15:0]         frame_cnt_o
`endif
);

  localparam int CNT_W = $clog2(RESULT_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(RESULT_W - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    FULL
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                drop_q, drop_d;
  logic [RESULT_W-1:0] shift_q, shift_d;
  logic [RESULT_W-1:0] sum_q, sum_d;
  logic                err_short_q, err_short_d;
  logic                err_ovf_q, err_ovf_d;
  logic                handshake;
  logic [RESULT_W-1:0] bit_word;

`ifdef SUM_DESER_FRAME_CNT_EN
  logic [15:0]         frame_cnt_q, frame_cnt_d;
`endif

  // State and datapath registers. The drop flag is loaded with ser_en_i on
  // reset, so a frame still streaming across reset is swallowed until its
  // enable falls, while a quiet line comes out of reset with drop clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      drop_q      <= ser_en_i;
      shift_q     <= '0;
      sum_q       <= '0;
      err_short_q <= 1'b0;
      err_ovf_q   <= 1'b0;
`ifdef SUM_DESER_FRAME_CNT_EN
      frame_cnt_q <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      drop_q      <= drop_d;
      shift_q     <= shift_d;
      sum_q       <= sum_d;
      err_short_q <= err_short_d;
      err_ovf_q   <= err_ovf_d;
`ifdef SUM_DESER_FRAME_CNT_EN
      frame_cnt_q <= frame_cnt_d;
`endif
    end
  end

  // Next-state logic: bit capture, frame completion, short/overflow detection.
  // sum_q is only reloaded when a frame completes, so the delivered word stays
  // on sum_o after its handshake even while the next frame is being shifted in.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    drop_d      = drop_q;
    shift_d     = shift_q;
    sum_d       = sum_q;
    err_short_d = 1'b0;
    err_ovf_d   = 1'b0;
    handshake   = (state_q == FULL) && sum_ready_i;
    bit_word    = RESULT_W'(ser_d_i) << cnt_q;
`ifdef SUM_DESER_FRAME_CNT_EN
    frame_cnt_d = handshake ? frame_cnt_q + 16'd1 : frame_cnt_q;
`endif

    if (!ser_en_i) begin
      drop_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (ser_en_i && !drop_q) begin
          shift_d = RESULT_W'(ser_d_i);
          cnt_d   = CNT_W'(1);
          state_d = SHIFT;
        end
      end

      SHIFT: begin
        if (ser_en_i) begin
          if (cnt_q == LAST_BIT) begin
            sum_d   = shift_q | bit_word;
            shift_d = '0;
            cnt_d   = '0;
            state_d = FULL;
          end else begin
            shift_d = shift_q | bit_word;
            cnt_d   = cnt_q + CNT_W'(1);
          end
        end else begin
          err_short_d = 1'b1;
          shift_d     = '0;
          cnt_d       = '0;
          state_d     = IDLE;
        end
      end

      FULL: begin
        if (handshake) begin
          if (ser_en_i && !drop_q) begin
            shift_d = RESULT_W'(ser_d_i);
            cnt_d   = CNT_W'(1);
            state_d = SHIFT;
          end else begin
            state_d = IDLE;
          end
        end else if (ser_en_i && !drop_q) begin
          err_ovf_d = 1'b1;
          drop_d    = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        shift_d = '0;
      end
    endcase
  end

  // Output logic: everything leaves the block straight from registers.
  always_comb begin
    sum_o       = sum_q;
    sum_valid_o = (state_q == FULL);
    err_short_o = err_short_q;
    err_ovf_o   = err_ovf_q;
`ifdef SUM_DESER_FRAME_CNT_EN
    frame_cnt_o = frame_cnt_q;
`endif
  end

endmodule

// File: tb/tb_serial_sum_deserializer.sv
// tb_serial_sum_deserializer
// Directed vector table for the scenarios of interest, a hand-written
// drop/handshake sequence, then randomized bursty traffic compared against a
// queue-based behavioural model. Define SUM_DESER_FRAME_CNT_EN to also check
// frame_cnt_o.
module tb_serial_sum_deserializer;

  localparam int W = 3;

  logic         clk = 1'b0;
  logic         rst;
  logic         ser_en_i;
  logic         ser_d_i;
  logic [W-1:0] sum_o;
  logic         sum_valid_o;
  logic         sum_ready_i;
  logic         err_short_o;
  logic         err_ovf_o;
`ifdef SUM_DESER_FRAME_CNT_EN
  logic [15:0]  frame_cnt_o;
`endif

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    logic         rst;
    logic         en;
    logic         d;
    logic         rdy;
    logic         valid;
    logic [W-1:0] sum;
    logic         sh;
    logic         ovf;
    string        name;
  } vec_t;

  vec_t vecs[$];

  // Behavioural model state
  bit           mBits[$];
  logic         mValid = 1'b0;
  logic [W-1:0] mSum   = '0;
  logic         mDrop  = 1'b0;
  logic         mShort = 1'b0;
  logic         mOvf   = 1'b0;
  logic [15:0]  mCnt   = '0;

  // Random stimulus variables
  logic rRst, rEn, rD, rRdy;
  int   burstLeft = 0;
  int   gapLeft   = 0;
  int   pick;

  serial_sum_deserializer #(.RESULT_W(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .ser_en_i    (ser_en_i),
    .ser_d_i     (ser_d_i),
    .sum_o       (sum_o),
    .sum_valid_o (sum_valid_o),
    .sum_ready_i (sum_ready_i),
    .err_short_o (err_short_o),
    .err_ovf_o   (err_ovf_o)
`ifdef SUM_DESER_FRAME_CNT_EN
    ,
    .frame_cnt_o (frame_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  // Model driven by the frame rules: collect bits of the current frame in a
  // queue, deliver their weighted sum once W of them have arrived.
  task automatic modelStep(input logic r, input logic en, input logic d, input logic rdy);
    bit          wasValid;
    bit          accepted;
    int unsigned val;
    mShort = 1'b0;
    mOvf   = 1'b0;
    if (r) begin
      mBits.delete();
      mValid = 1'b0;
      mSum   = '0;
      mDrop  = en;
      mCnt   = '0;
      return;
    end
    wasValid = mValid;
    accepted = mValid && rdy;
    if (accepted) begin
      mValid = 1'b0;
      mCnt   = mCnt + 16'd1;
    end
    if (en) begin
      if (!mDrop) begin
        if (!wasValid || accepted) begin
          mBits.push_back(d);
          if (mBits.size() == W) begin
            val = 0;
            foreach (mBits[k]) val += int'(mBits[k]) << k;
            mSum   = W'(val);
            mValid = 1'b1;
            mBits.delete();
          end
        end else begin
          mOvf  = 1'b1;
          mDrop = 1'b1;
        end
      end
    end else begin
      if (mBits.size() != 0) mShort = 1'b1;
      mBits.delete();
      mDrop = 1'b0;
    end
  endtask

  task automatic applyStimulus(input logic r, input logic en, input logic d, input logic rdy);
    @(negedge clk);
    rst         = r;
    ser_en_i    = en;
    ser_d_i     = d;
    sum_ready_i = rdy;
    @(posedge clk);
    modelStep(r, en, d, rdy);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic ev, input logic [W-1:0] es,
                             input logic esh, input logic eov);
    compared++;
    if (sum_valid_o !== ev || sum_o !== es || err_short_o !== esh || err_ovf_o !== eov) begin
      mismatched++;
      $display("[TB] FAIL %s @%0t: got valid=%0b sum=%0h short=%0b ovf=%0b, expected valid=%0b sum=%0h short=%0b ovf=%0b",
               name, $time, sum_valid_o, sum_o, err_short_o, err_ovf_o, ev, es, esh, eov);
    end
  endtask

`ifdef SUM_DESER_FRAME_CNT_EN
  task automatic checkCount(input string name, input logic [15:0] exp);
    compared++;
    if (frame_cnt_o !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s @%0t: got frame_cnt=%0d, expected %0d", name, $time, frame_cnt_o, exp);
    end
  endtask
`endif

  task automatic addVec(input string name, input logic r, input logic en, input logic d,
                        input logic rdy, input logic ev, input logic [W-1:0] es,
                        input logic esh, input logic eov);
    vec_t v;
    v.rst = r; v.en = en; v.d = d; v.rdy = rdy;
    v.valid = ev; v.sum = es; v.sh = esh; v.ovf = eov; v.name = name;
    vecs.push_back(v);
  endtask

  initial begin
    rst         = 1'b1;
    ser_en_i    = 1'b0;
    ser_d_i     = 1'b0;
    sum_ready_i = 1'b0;

    // Reset state
    addVec("reset",   1, 0, 0, 0, 0, 3'b000, 0, 0);
    addVec("reset",   1, 0, 0, 0, 0, 3'b000, 0, 0);
    addVec("idle",    0, 0, 0, 1, 0, 3'b000, 0, 0);
    // Single frame 101, ready high: valid exactly one cycle
    addVec("single",  0, 1, 1, 1, 0, 3'b000, 0, 0);
    addVec("single",  0, 1, 0, 1, 0, 3'b000, 0, 0);
    addVec("single",  0, 1, 1, 1, 1, 3'b101, 0, 0);
    addVec("single",  0, 0, 0, 1, 0, 3'b101, 0, 0);
    addVec("single",  0, 0, 0, 1, 0, 3'b101, 0, 0);
    // Back-pressure on 110: valid held six cycles
    addVec("bp",      0, 1, 0, 0, 0, 3'b101, 0, 0);
    addVec("bp",      0, 1, 1, 0, 0, 3'b101, 0, 0);
    addVec("bp",      0, 1, 1, 0, 1, 3'b110, 0, 0);
    for (int i = 0; i < 5; i++) addVec("bp_hold", 0, 0, 0, 0, 1, 3'b110, 0, 0);
    addVec("bp",      0, 0, 0, 1, 0, 3'b110, 0, 0);
    // Short frame then a good 011
    addVec("short",   0, 1, 1, 1, 0, 3'b110, 0, 0);
    addVec("short",   0, 1, 1, 1, 0, 3'b110, 0, 0);
    addVec("short",   0, 0, 0, 1, 0, 3'b110, 1, 0);
    addVec("short",   0, 0, 0, 1, 0, 3'b110, 0, 0);
    addVec("after_s", 0, 1, 1, 1, 0, 3'b110, 0, 0);
    addVec("after_s", 0, 1, 1, 1, 0, 3'b110, 0, 0);
    addVec("after_s", 0, 1, 0, 1, 1, 3'b011, 0, 0);
    addVec("after_s", 0, 0, 0, 1, 0, 3'b011, 0, 0);
    // Overflow: A=111 held, B=010 dropped, C=001 delivered
    addVec("ovf_a",   0, 1, 1, 0, 0, 3'b011, 0, 0);
    addVec("ovf_a",   0, 1, 1, 0, 0, 3'b011, 0, 0);
    addVec("ovf_a",   0, 1, 1, 0, 1, 3'b111, 0, 0);
    addVec("ovf_a",   0, 0, 0, 0, 1, 3'b111, 0, 0);
    addVec("ovf_b",   0, 1, 0, 0, 1, 3'b111, 0, 1);
    addVec("ovf_b",   0, 1, 1, 0, 1, 3'b111, 0, 0);
    addVec("ovf_b",   0, 1, 0, 0, 1, 3'b111, 0, 0);
    addVec("ovf_b",   0, 0, 0, 0, 1, 3'b111, 0, 0);
    addVec("ovf_a_hs",0, 0, 0, 1, 0, 3'b111, 0, 0);
    addVec("ovf_c",   0, 1, 1, 1, 0, 3'b111, 0, 0);
    addVec("ovf_c",   0, 1, 0, 1, 0, 3'b111, 0, 0);
    addVec("ovf_c",   0, 1, 0, 1, 1, 3'b001, 0, 0);
    addVec("ovf_c",   0, 0, 0, 1, 0, 3'b001, 0, 0);
    // Back-to-back 100 then 011, ready always high
    addVec("b2b",     0, 1, 0, 1, 0, 3'b001, 0, 0);
    addVec("b2b",     0, 1, 0, 1, 0, 3'b001, 0, 0);
    addVec("b2b",     0, 1, 1, 1, 1, 3'b100, 0, 0);
    addVec("b2b",     0, 1, 1, 1, 0, 3'b100, 0, 0);
    addVec("b2b",     0, 1, 1, 1, 0, 3'b100, 0, 0);
    addVec("b2b",     0, 1, 0, 1, 1, 3'b011, 0, 0);
    addVec("b2b",     0, 0, 0, 1, 0, 3'b011, 0, 0);
    // Reset mid-frame, trailing bits ignored, then clean 101
    addVec("rst_mid", 0, 1, 1, 1, 0, 3'b011, 0, 0);
    addVec("rst_mid", 1, 1, 0, 1, 0, 3'b000, 0, 0);
    addVec("rst_mid", 0, 1, 1, 1, 0, 3'b000, 0, 0);
    addVec("rst_mid", 0, 0, 0, 1, 0, 3'b000, 0, 0);
    addVec("rst_new", 0, 1, 1, 1, 0, 3'b000, 0, 0);
    addVec("rst_new", 0, 1, 0, 1, 0, 3'b000, 0, 0);
    addVec("rst_new", 0, 1, 1, 1, 1, 3'b101, 0, 0);
    addVec("rst_new", 0, 0, 0, 1, 0, 3'b101, 0, 0);

    $display("[TB] directed table: %0d vectors", vecs.size());
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].rst, vecs[i].en, vecs[i].d, vecs[i].rdy);
      checkOutput(vecs[i].name, vecs[i].valid, vecs[i].sum, vecs[i].sh, vecs[i].ovf);
    end
`ifdef SUM_DESER_FRAME_CNT_EN
    checkCount("cnt_after_rst", 16'd1);
`endif

    // Handshake while a frame is being dropped: remainder ignored, no short
    $display("[TB] hand sequence: handshake during drop");
    applyStimulus(0, 1, 0, 0); checkOutput("hs_drop", 0, 3'b101, 0, 0);
    applyStimulus(0, 1, 1, 0); checkOutput("hs_drop", 0, 3'b101, 0, 0);
    applyStimulus(0, 1, 1, 0); checkOutput("hs_drop", 1, 3'b110, 0, 0);
    applyStimulus(0, 1, 1, 0); checkOutput("hs_drop_ovf", 1, 3'b110, 0, 1);
    applyStimulus(0, 1, 1, 1); checkOutput("hs_drop_hs", 0, 3'b110, 0, 0);
    applyStimulus(0, 1, 1, 1); checkOutput("hs_drop_ign", 0, 3'b110, 0, 0);
    applyStimulus(0, 0, 0, 1); checkOutput("hs_drop_end", 0, 3'b110, 0, 0);
    // One-bit frame is short
    applyStimulus(0, 1, 1, 1); checkOutput("short1", 0, 3'b110, 0, 0);
    applyStimulus(0, 0, 0, 1); checkOutput("short1_err", 0, 3'b110, 1, 0);
    applyStimulus(0, 0, 0, 1); checkOutput("short1_end", 0, 3'b110, 0, 0);
`ifdef SUM_DESER_FRAME_CNT_EN
    checkCount("cnt_after_hand", 16'd2);
`endif

    // Randomized bursty traffic against the model
    $display("[TB] random phase");
    applyStimulus(1, 0, 0, 0);
    checkOutput("rand_reset", mValid, mSum, mShort, mOvf);
    for (int cyc = 0; cyc < 3000; cyc++) begin
      rRst = ($urandom_range(0, 249) == 0);
      if (burstLeft == 0 && gapLeft == 0) begin
        gapLeft   = $urandom_range(0, 2);
        pick      = $urandom_range(0, 9);
        burstLeft = (pick < 7) ? W : $urandom_range(1, W + 2);
      end
      if (gapLeft > 0) begin
        rEn = 1'b0;
        gapLeft--;
      end else begin
        rEn = 1'b1;
        burstLeft--;
      end
      rD   = 1'($urandom_range(0, 1));
      rRdy = ($urandom_range(0, 9) < 6);
      applyStimulus(rRst, rEn, rD, rRdy);
      checkOutput("rand", mValid, mSum, mShort, mOvf);
`ifdef SUM_DESER_FRAME_CNT_EN
      checkCount("rand_cnt", mCnt);
`endif
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
